// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - Data-request width codes (byte / half / word; code 2'b11 is illegal).
//   - Arbiter FSM state encoding.
//   - word_addr(): strip the byte offset from an address.
package mem_arbiter_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUS_IF = 2'b01,
    ST_BUS_DM = 2'b10
  } state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for data-port requests.
// Ports:
//   width      in  2   access width code (byte/half/word, 11 illegal)
//   addr       in  32  byte address
//   wdata      in  32  write data, right-justified
//   be         out 4   byte enables for the addressed lanes
//   addr_word  out 32  word-aligned bus address
//   wdata_lane out 32  write data replicated so it sits in the addressed lanes
//   misaligned out 1   access crosses its natural alignment or width is illegal
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] addr_word,
  output logic [31:0] wdata_lane,
  output logic        misaligned
);

  assign addr_word = word_addr(addr);

  // NOTE: every output gets a default before the case so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    misaligned = 1'b0;
    case (width)
      WIDTH_BYTE: begin
        be         = 4'b0001 << addr[1:0];
        wdata_lane = {4{wdata[7:0]}};
      end
      WIDTH_HALF: begin
        be         = 4'b0011 << addr[1:0];
        wdata_lane = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      WIDTH_WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        misaligned = (addr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single request/ack memory bus.
// Data requests normally win; after MAX_DM_BURST consecutive data grants
// with fetch waiting, fetch is served once. A bus transaction that sees no
// ack within TIMEOUT request cycles is aborted and reported.
// Ports:
//   clk, rst                       clock, async active-high reset
//   if_req_i/if_addr_i             fetch request (always a word read)
//   if_gnt_o/if_rvalid_o/if_rdata_o fetch grant pulse, completion, data
//   dm_req_i/dm_we_i/dm_width_i/dm_addr_i/dm_wdata_i  data request
//   dm_gnt_o/dm_rvalid_o/dm_rdata_o/dm_err_o  data grant, completion, data, error
//   bus_req_o/bus_we_o/bus_be_o/bus_addr_o/bus_wdata_o  bus request fields
//   bus_ack_i/bus_rdata_i          bus acknowledge and read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT      = 8,
  parameter int MAX_DM_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [1:0]  dm_width_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        dm_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam int BURST_W = $clog2(MAX_DM_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DM_BURST);

  state_e state, state_next;
  logic   if_gnt, dm_gnt;

  logic [3:0]  dm_be;
  logic [31:0] dm_addr_word, dm_wdata_lane;
  logic        dm_misaligned;

  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr, lat_wdata;

  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;

  logic        if_rvalid_q, dm_rvalid_q, dm_err_q;
  logic [31:0] rdata_q;

  logic timeout_hit, bus_done;

  mem_lane_align u_lane_align (
    .width      (dm_width_i),
    .addr       (dm_addr_i),
    .wdata      (dm_wdata_i),
    .be         (dm_be),
    .addr_word  (dm_addr_word),
    .wdata_lane (dm_wdata_lane),
    .misaligned (dm_misaligned)
  );

  // The last request cycle without ack ends the transaction as a timeout.
  assign timeout_hit = bus_req_o && !bus_ack_i && (wait_cnt == WAIT_LAST);
  assign bus_done    = bus_ack_i || timeout_hit;

  // Grants are combinational so a waiting requester is accepted in the same
  // cycle; they are masked during reset so every output reads 0.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst) begin
          if (if_req_i && (!dm_req_i || burst_cnt == BURST_MAX)) begin
            if_gnt     = 1'b1;
            state_next = ST_BUS_IF;
          end else if (dm_req_i) begin
            dm_gnt = 1'b1;
            // A misaligned access never reaches the bus; it is answered
            // with an error straight from IDLE.
            if (!dm_misaligned) state_next = ST_BUS_DM;
          end
        end
      end
      ST_BUS_IF, ST_BUS_DM: if (bus_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_be    <= 4'b0000;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else if (if_gnt) begin
      lat_we    <= 1'b0;
      lat_be    <= 4'b1111;
      lat_addr  <= word_addr(if_addr_i);
      lat_wdata <= 32'h0;
    end else if (dm_gnt && !dm_misaligned) begin
      lat_we    <= dm_we_i;
      lat_be    <= dm_be;
      lat_addr  <= dm_addr_word;
      lat_wdata <= dm_wdata_lane;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if (state == ST_IDLE) wait_cnt <= '0;
      else if (!bus_ack_i)  wait_cnt <= wait_cnt + 1'b1;

      // Burst credit only moves while idle: reset when fetch is absent or
      // served, otherwise count data grants that made fetch wait.
      if (state == ST_IDLE) begin
        if (!if_req_i || if_gnt)                  burst_cnt <= '0;
        else if (dm_gnt && burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_err_q    <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      if_rvalid_q <= (state == ST_BUS_IF) && bus_done;
      dm_rvalid_q <= ((state == ST_BUS_DM) && bus_done) || (dm_gnt && dm_misaligned);
      dm_err_q    <= ((state == ST_BUS_DM) && timeout_hit) || (dm_gnt && dm_misaligned);
      rdata_q     <= (bus_req_o && bus_ack_i && !lat_we) ? bus_rdata_i : 32'h0;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign dm_gnt_o    = dm_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rvalid_q ? rdata_q : 32'h0;
  assign dm_rvalid_o = dm_rvalid_q;
  assign dm_rdata_o  = dm_rvalid_q ? rdata_q : 32'h0;
  assign dm_err_o    = dm_err_q;

  assign bus_req_o   = (state != ST_IDLE);
  assign bus_we_o    = bus_req_o && lat_we;
  assign bus_be_o    = bus_req_o ? lat_be : 4'b0000;
  assign bus_addr_o  = bus_req_o ? lat_addr : 32'h0;
  assign bus_wdata_o = (bus_req_o && lat_we) ? lat_wdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int TIMEOUT      = 8;
  localparam int MAX_DM_BURST = 4;
  localparam int NV           = 11;
  localparam int RAND_CYCLES  = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i, dm_we_i;
  logic [1:0]  dm_width_i;
  logic [31:0] dm_addr_i, dm_wdata_i;
  logic        dm_gnt_o, dm_rvalid_o, dm_err_o;
  logic [31:0] dm_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [138:0] all_outs;
  assign all_outs = {if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o,
                     dm_rdata_o, dm_err_o, bus_req_o, bus_we_o, bus_be_o,
                     bus_addr_o, bus_wdata_o};

  mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_DM_BURST(MAX_DM_BURST)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_width_i(dm_width_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = 32'h0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_width_i  = 2'b00;
    dm_addr_i   = 32'h0;
    dm_wdata_i  = 32'h0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
  endtask

  task automatic dm_drive(input logic we, input logic [1:0] w, input logic [31:0] a,
                          input logic [31:0] d);
    dm_req_i   = 1'b1;
    dm_we_i    = we;
    dm_width_i = w;
    dm_addr_i  = a;
    dm_wdata_i = d;
  endtask

  // Directed alignment vectors: request fields and what must appear on the bus.
  typedef struct {
    logic        we;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rd;
    logic        err;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[NV];

  // Reference model state (random phase)
  int          m_owner;      // 0 none, 1 fetch, 2 data
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  int          m_waited, m_burst;
  logic        r_if, r_dm, r_err;
  logic [31:0] r_data;

  // Random requesters
  logic        if_pend, dm_pend;

  initial begin
    logic [1:0] grants[6];
    logic [1:0] exp_grants[6];
    int         n_g, cnt;
    logic       saw_rvalid;
    logic       e_if, e_dm, n_if, n_dm, n_err;
    logic [31:0] n_data;
    int          size, off, ack_div;
    logic        mis;

    vecs[0]  = '{we:1'b1, width:2'b00, addr:32'h103, wdata:32'h123456AB, bus_rd:32'h55555555,
                 err:1'b0, be:4'b1000, baddr:32'h100, bwdata:32'hABABABAB, rdata:32'h0};
    vecs[1]  = '{we:1'b0, width:2'b00, addr:32'h102, wdata:32'hFFFFFFFF, bus_rd:32'h11223344,
                 err:1'b0, be:4'b0100, baddr:32'h100, bwdata:32'h0, rdata:32'h11223344};
    vecs[2]  = '{we:1'b1, width:2'b01, addr:32'h202, wdata:32'h0000BEEF, bus_rd:32'h0,
                 err:1'b0, be:4'b1100, baddr:32'h200, bwdata:32'hBEEFBEEF, rdata:32'h0};
    vecs[3]  = '{we:1'b1, width:2'b01, addr:32'h200, wdata:32'hFFFF1234, bus_rd:32'h9,
                 err:1'b0, be:4'b0011, baddr:32'h200, bwdata:32'h12341234, rdata:32'h0};
    vecs[4]  = '{we:1'b0, width:2'b10, addr:32'h30C, wdata:32'h0, bus_rd:32'hCAFEF00D,
                 err:1'b0, be:4'b1111, baddr:32'h30C, bwdata:32'h0, rdata:32'hCAFEF00D};
    vecs[5]  = '{we:1'b1, width:2'b10, addr:32'h400, wdata:32'h89ABCDEF, bus_rd:32'h77777777,
                 err:1'b0, be:4'b1111, baddr:32'h400, bwdata:32'h89ABCDEF, rdata:32'h0};
    vecs[6]  = '{we:1'b0, width:2'b01, addr:32'h101, wdata:32'h0, bus_rd:32'h0,
                 err:1'b1, be:4'b0, baddr:32'h0, bwdata:32'h0, rdata:32'h0};
    vecs[7]  = '{we:1'b1, width:2'b10, addr:32'h102, wdata:32'h1, bus_rd:32'h0,
                 err:1'b1, be:4'b0, baddr:32'h0, bwdata:32'h0, rdata:32'h0};
    vecs[8]  = '{we:1'b0, width:2'b11, addr:32'h100, wdata:32'h0, bus_rd:32'h0,
                 err:1'b1, be:4'b0, baddr:32'h0, bwdata:32'h0, rdata:32'h0};
    vecs[9]  = '{we:1'b1, width:2'b00, addr:32'h001, wdata:32'h0000005A, bus_rd:32'h3,
                 err:1'b0, be:4'b0010, baddr:32'h000, bwdata:32'h5A5A5A5A, rdata:32'h0};
    vecs[10] = '{we:1'b0, width:2'b01, addr:32'h302, wdata:32'h0, bus_rd:32'hA5A51234,
                 err:1'b0, be:4'b1100, baddr:32'h300, bwdata:32'h0, rdata:32'hA5A51234};

    // ---------------- reset state ----------------
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", all_outs, '0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- simultaneous fetch + data ----------------
    @(negedge clk);
    if_req_i  = 1'b1;
    if_addr_i = 32'h206;
    dm_drive(1'b0, 2'b10, 32'h100, 32'h0);
    #1 check("sim_c0_gnt", {if_gnt_o, dm_gnt_o}, 2'b01);
    @(negedge clk);
    dm_req_i    = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hDEADBEEF;
    #1 check("sim_c1_bus", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o}, {1'b1, 1'b0, 4'hF, 32'h100});
    check("sim_c1_no_gnt", {if_gnt_o, dm_gnt_o}, 2'b00);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1 check("sim_c2_dm_resp", {dm_rvalid_o, dm_err_o, dm_rdata_o}, {1'b1, 1'b0, 32'hDEADBEEF});
    check("sim_c2_if_gnt", {if_gnt_o, dm_gnt_o}, 2'b10);
    @(negedge clk);
    if_req_i    = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h13579BDF;
    #1 check("sim_c3_fetch_bus", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o}, {1'b1, 1'b0, 4'hF, 32'h204});
    check("sim_c3_dm_rvalid_pulse", dm_rvalid_o, 1'b0);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1 check("sim_c4_if_resp", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h13579BDF});

    // ---------------- alignment table ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      dm_drive(vecs[i].we, vecs[i].width, vecs[i].addr, vecs[i].wdata);
      bus_ack_i = 1'b0;
      #1 check($sformatf("vec%0d_gnt", i), {if_gnt_o, dm_gnt_o}, 2'b01);
      @(negedge clk);
      dm_req_i = 1'b0;
      if (vecs[i].err) begin
        #1 check($sformatf("vec%0d_err_resp", i), {bus_req_o, dm_rvalid_o, dm_err_o, dm_rdata_o},
                 {1'b0, 1'b1, 1'b1, 32'h0});
      end else begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = vecs[i].bus_rd;
        #1 check($sformatf("vec%0d_bus", i), {bus_req_o, bus_we_o, bus_be_o, bus_addr_o},
                 {1'b1, vecs[i].we, vecs[i].be, vecs[i].baddr});
        check($sformatf("vec%0d_wdata", i), bus_wdata_o, vecs[i].bwdata);
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1 check($sformatf("vec%0d_resp", i), {dm_rvalid_o, dm_err_o, dm_rdata_o},
                 {1'b1, 1'b0, vecs[i].rdata});
      end
    end

    // ---------------- burst limit ----------------
    exp_grants = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    n_g = 0;
    for (int c = 0; c < 40 && n_g < 6; c++) begin
      @(negedge clk);
      if_req_i  = 1'b1;
      if_addr_i = 32'h40;
      dm_drive(1'b0, 2'b10, 32'h80, 32'h0);
      bus_ack_i = 1'b1;
      #1;
      if (dm_gnt_o)      begin grants[n_g] = 2'b01; n_g++; end
      else if (if_gnt_o) begin grants[n_g] = 2'b10; n_g++; end
    end
    check("burst_grant_count", n_g, 6);
    for (int i = 0; i < 6 && i < n_g; i++)
      check($sformatf("burst_grant%0d", i), grants[i], exp_grants[i]);
    @(negedge clk);
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    @(negedge clk);
    bus_ack_i = 1'b0;

    // ---------------- bus timeout ----------------
    @(negedge clk);
    dm_drive(1'b0, 2'b10, 32'h180, 32'h0);
    #1 check("to_gnt", dm_gnt_o, 1'b1);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      dm_req_i = 1'b0;
      #1;
      if (!bus_req_o) break;
      cnt++;
    end
    check("to_req_cycles", cnt, TIMEOUT);
    check("to_resp", {dm_rvalid_o, dm_err_o, dm_rdata_o}, {1'b1, 1'b1, 32'h0});
    @(negedge clk);
    if_req_i  = 1'b1;
    if_addr_i = 32'h10;
    #1 check("to_idle_gnt", {if_gnt_o, dm_rvalid_o, dm_err_o}, 3'b100);
    @(negedge clk);
    if_req_i    = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1 check("to_fetch_resp", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h0BADF00D});

    // ---------------- reset during data transaction ----------------
    @(negedge clk);
    dm_drive(1'b1, 2'b10, 32'h500, 32'h11111111);
    #1 check("rst_gnt", dm_gnt_o, 1'b1);
    @(negedge clk);
    dm_req_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("rst_waiting", {bus_req_o, bus_we_o}, 2'b11);
    #2;
    rst      = 1'b1;
    if_req_i = 1'b1;
    dm_req_i = 1'b1;
    #1 check("rst_outputs_now", all_outs, '0);
    @(negedge clk);
    #1 check("rst_outputs_held", all_outs, '0);
    rst      = 1'b0;
    if_req_i = 1'b0;
    dm_drive(1'b0, 2'b00, 32'h7, 32'h0);
    #1 check("rst_first_gnt", {dm_gnt_o, dm_rvalid_o, if_rvalid_o}, 3'b100);
    @(negedge clk);
    dm_req_i    = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h44332211;
    #1 check("rst_after_bus", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o, dm_rvalid_o},
             {1'b1, 1'b0, 4'b1000, 32'h4, 1'b0});
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1 check("rst_after_resp", {dm_rvalid_o, dm_err_o, dm_rdata_o}, {1'b1, 1'b0, 32'h44332211});
    saw_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 saw_rvalid = saw_rvalid | dm_rvalid_o | if_rvalid_o;
    end
    check("rst_no_stray_rvalid", saw_rvalid, 1'b0);

    // ---------------- randomized against reference model ----------------
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_owner = 0; m_we = 1'b0; m_be = 4'b0; m_addr = 32'h0; m_wdata = 32'h0;
    m_waited = 0; m_burst = 0;
    r_if = 1'b0; r_dm = 1'b0; r_err = 1'b0; r_data = 32'h0;
    if_pend = 1'b0;
    dm_pend = 1'b0;

    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      @(negedge clk);
      if (!if_pend && $urandom_range(3) == 0) begin
        if_pend   = 1'b1;
        if_addr_i = $urandom;
      end
      if (!dm_pend && $urandom_range(2) == 0) begin
        dm_pend    = 1'b1;
        dm_we_i    = 1'($urandom_range(1));
        dm_width_i = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
        dm_addr_i  = $urandom;
        dm_wdata_i = $urandom;
      end
      if_req_i    = if_pend;
      dm_req_i    = dm_pend;
      ack_div     = (cyc < RAND_CYCLES / 2) ? 2 : 6;
      bus_ack_i   = ($urandom_range(ack_div - 1) == 0);
      bus_rdata_i = $urandom;
      #1;

      // expected behaviour this cycle
      e_if = (m_owner == 0) && if_req_i && (!dm_req_i || m_burst == MAX_DM_BURST);
      e_dm = (m_owner == 0) && dm_req_i && !e_if;
      check($sformatf("rnd%0d_gnt", cyc), {if_gnt_o, dm_gnt_o}, {e_if, e_dm});
      check($sformatf("rnd%0d_bus", cyc), {bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o},
            (m_owner != 0) ? {1'b1, m_we, m_be, m_addr, (m_we ? m_wdata : 32'h0)} : 70'h0);
      check($sformatf("rnd%0d_resp", cyc),
            {if_rvalid_o, dm_rvalid_o, dm_err_o, if_rdata_o, dm_rdata_o},
            {r_if, r_dm, r_err, (r_if ? r_data : 32'h0), (r_dm ? r_data : 32'h0)});

      // advance the model across the coming clock edge
      n_if = 1'b0; n_dm = 1'b0; n_err = 1'b0; n_data = 32'h0;
      if (m_owner != 0) begin
        if (bus_ack_i) begin
          n_if    = (m_owner == 1);
          n_dm    = (m_owner == 2);
          n_data  = m_we ? 32'h0 : bus_rdata_i;
          m_owner = 0;
        end else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin
            n_if    = (m_owner == 1);
            n_dm    = (m_owner == 2);
            n_err   = (m_owner == 2);
            m_owner = 0;
          end
        end
      end else begin
        if (e_if || !if_req_i)                     m_burst = 0;
        else if (e_dm && m_burst < MAX_DM_BURST)   m_burst++;
        if (e_if) begin
          m_owner  = 1;
          m_waited = 0;
          m_we     = 1'b0;
          m_be     = 4'hF;
          m_addr   = if_addr_i - (if_addr_i % 4);
        end else if (e_dm) begin
          size = 1 << dm_width_i;
          off  = int'(dm_addr_i % 4);
          mis  = (dm_width_i == 2'b11) || (off % size != 0);
          if (mis) begin
            n_dm  = 1'b1;
            n_err = 1'b1;
          end else begin
            m_owner  = 2;
            m_waited = 0;
            m_we     = dm_we_i;
            m_be     = 4'(((1 << size) - 1) << off);
            m_addr   = dm_addr_i - (dm_addr_i % 4);
            case (size)
              1:       m_wdata = 32'(dm_wdata_i[7:0] * 32'h01010101);
              2:       m_wdata = 32'(dm_wdata_i[15:0] * 32'h00010001);
              default: m_wdata = dm_wdata_i;
            endcase
          end
        end
      end
      r_if = n_if; r_dm = n_dm; r_err = n_err; r_data = n_data;

      if (if_gnt_o) if_pend = 1'b0;
      if (dm_gnt_o) dm_pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
